// File: rtl/ring_sched_pkg.sv
// Shared types and helpers for the ring buffer read scheduler.
// Optional urgent path for queue 0 is enabled with RING_SCHED_URGENT_EN.
package ring_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_t;

    // Upper bound on queues the round-robin helper can search.
    localparam int MAX_Q  = 32;
    localparam int MAX_QW = 5;

    typedef struct packed {
        logic              found;
        logic [MAX_QW-1:0] idx;
    } rr_pick_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of mask searching circularly from start over num_q entries.
    function automatic rr_pick_t first_set_rr(input logic [MAX_Q-1:0] mask,
                                              input int num_q,
                                              input int start);
        rr_pick_t pick;
        int       j;
        pick = '0;
        j    = 0;
        for (int i = 0; i < MAX_Q; i++) begin
            if (!pick.found && (i < num_q)) begin
                j = start + i;
                if (j >= num_q) begin
                    j = j - num_q;
                end
                if (mask[j[MAX_QW-1:0]]) begin
                    pick.found = 1'b1;
                    pick.idx   = j[MAX_QW-1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ring_sched_lat_pipe.sv
// RD_LAT-deep delay line carrying (read issued, queue index) to the data-return side.
// Cleared synchronously so in-flight returns are dropped on reset.
module ring_sched_lat_pipe
    import ring_sched_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int SEL_W  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_vld,
    input  logic [SEL_W-1:0] in_sel,
    output logic             out_vld,
    output logic [SEL_W-1:0] out_sel
);

    logic [RD_LAT-1:0] vld_q;
    logic [SEL_W-1:0]  sel_q [RD_LAT];

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                sel_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld;
            sel_q[0] <= in_sel;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                sel_q[i] <= sel_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[RD_LAT-1];
    assign out_sel = sel_q[RD_LAT-1];

endmodule

// File: rtl/ring_buff_rd_sched.sv
// Round-robin read scheduler draining NUM_Q ring buffers into one consumer port.
// Define RING_SCHED_URGENT_EN to add the I_Urgent priority grant for queue 0.
module ring_buff_rd_sched
    import ring_sched_pkg::*;
#(
    parameter int NUM_Q     = 4,
    parameter int BURST_LEN = 4,
    parameter int RD_LAT    = 1,
    localparam int SEL_W    = sel_width(NUM_Q)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NUM_Q-1:0] I_Empty,
    input  logic             I_Rdy,
`ifdef RING_SCHED_URGENT_EN
    input  logic             I_Urgent,
`endif
    output logic [NUM_Q-1:0] O_Re,
    output logic [SEL_W-1:0] O_Sel,
    output logic             O_Vld,
    output logic [SEL_W-1:0] O_VSel,
    output logic             O_Busy
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_Q - 1);

    sched_state_t     state, state_nxt;
    logic [SEL_W-1:0] r_cur, r_cur_nxt;
    logic [SEL_W-1:0] r_last, r_last_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             urg_q, urg_nxt;

    logic [MAX_Q-1:0] avail;
    int               start;
    rr_pick_t         pick;
    logic             cur_empty;
    logic             rd;
    logic             urgent_hit;

`ifdef RING_SCHED_URGENT_EN
    assign urgent_hit = I_Urgent & ~I_Empty[0];
`else
    assign urgent_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            r_cur  <= '0;
            r_last <= SEL_LAST;
            cnt    <= '0;
            urg_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            r_cur  <= r_cur_nxt;
            r_last <= r_last_nxt;
            cnt    <= cnt_nxt;
            urg_q  <= urg_nxt;
        end
    end

    always_comb begin
        avail      = MAX_Q'(~I_Empty);
        start      = (r_last == SEL_LAST) ? 0 : int'(r_last) + 1;
        pick       = first_set_rr(avail, NUM_Q, start);
        cur_empty  = I_Empty[r_cur];
        rd         = (state == BURST) & I_Rdy & ~cur_empty;
        O_Re       = rd ? (NUM_Q'(1) << r_cur) : '0;

        state_nxt  = state;
        r_cur_nxt  = r_cur;
        r_last_nxt = r_last;
        cnt_nxt    = cnt;
        urg_nxt    = urg_q;

        case (state)
            IDLE: begin
                // The grant is registered; the first read follows next cycle.
                if (urgent_hit) begin
                    r_cur_nxt = '0;
                    cnt_nxt   = '0;
                    urg_nxt   = 1'b1;
                    state_nxt = BURST;
                end else if (pick.found) begin
                    r_cur_nxt = SEL_W'(pick.idx);
                    cnt_nxt   = '0;
                    urg_nxt   = 1'b0;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (cur_empty || (rd && (cnt == CNT_LAST))) begin
                    state_nxt = IDLE;
                    // An urgent grant leaves the rotation point untouched.
                    if (!urg_q) begin
                        r_last_nxt = r_cur;
                    end
                end else if (rd) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign O_Sel  = r_cur;
    assign O_Busy = (state == BURST);

    ring_sched_lat_pipe #(
        .RD_LAT (RD_LAT),
        .SEL_W  (SEL_W)
    ) u_lat_pipe (
        .clock   (clock),
        .reset   (reset),
        .in_vld  (|O_Re),
        .in_sel  (r_cur),
        .out_vld (O_Vld),
        .out_sel (O_VSel)
    );

endmodule
